// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment display driver.
// Scans DIGITS digits round-robin with a dwell of 2^DIV cycles per digit,
// blanks the first BLANK cycles of every slot to avoid ghosting, and
// double-buffers the display data so a new snapshot only takes effect at a
// frame boundary. Segments and digit selects are active low.
module seven_seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 16,
  parameter int BLANK  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   values_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     digit_en_i,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     sel_o,
  output logic                  frame_o
);

  localparam int                IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV-1:0]    CNT_MAX  = '1;
  localparam logic [DIV-1:0]    BLANK_C  = DIV'(BLANK);
  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

  logic [DIV-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q, idx_d;

  logic [4*DIGITS-1:0] pend_vals_q, pend_vals_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                pend_q, pend_d;

  logic [4*DIGITS-1:0] act_vals_q, act_vals_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   act_en_q, act_en_d;

  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_q, frame_d;

  logic                wrap;
  logic [3:0]          nibble;

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] pat;
    pat = 7'h7F;
    case (n)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Dwell counter and digit index; the last cycle of the last digit is the frame wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    wrap  = (cnt_q == CNT_MAX) && (idx_q == IDX_LAST);
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: loads go to pending, pending moves to active only on the wrap,
  // and a load on the wrap itself goes straight to active so digit 0 shows it.
  always_comb begin
    pend_vals_d = pend_vals_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_d      = pend_q;
    act_vals_d  = act_vals_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    if (load_i) begin
      pend_vals_d = values_i;
      pend_dp_d   = dp_i;
      pend_en_d   = digit_en_i;
      pend_d      = 1'b1;
    end
    if (wrap) begin
      if (load_i) begin
        act_vals_d = values_i;
        act_dp_d   = dp_i;
        act_en_d   = digit_en_i;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        act_vals_d = pend_vals_q;
        act_dp_d   = pend_dp_q;
        act_en_d   = pend_en_q;
        pend_d     = 1'b0;
      end
    end
  end

  // Next display outputs from the current slot position, blanked at slot start or when disabled.
  always_comb begin
    nibble  = act_vals_q[{idx_q, 2'b00} +: 4];
    seg_d   = 8'hFF;
    sel_d   = '1;
    frame_d = wrap;
    if ((cnt_q >= BLANK_C) && act_en_q[idx_q]) begin
      sel_d = ~(SEL_ONE << idx_q);
      seg_d = {~act_dp_q[idx_q], decode(nibble)};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_vals_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_q      <= 1'b0;
      act_vals_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      seg_q       <= 8'hFF;
      sel_q       <= '1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_vals_q <= pend_vals_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_q      <= pend_d;
      act_vals_q  <= act_vals_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign sel_o   = sel_q;
  assign frame_o = frame_q;

endmodule
